// File: rtl/int_div_rem_fu_pkg.sv
// Shared types and constants for the RV32M divide/remainder unit.
// Operand width, op encoding and small sign helpers used by the datapath.
package int_div_rem_fu_pkg;

  localparam int RSZ    = 32;
  localparam int CNT_SZ = $clog2(RSZ);

  localparam logic [CNT_SZ-1:0] CNT_LAST = CNT_SZ'(RSZ - 1);
  localparam logic [CNT_SZ-1:0] CNT_ONE  = CNT_SZ'(1);

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } IDR_OP_TYPE;

  function automatic logic is_signed_op(input IDR_OP_TYPE i_op);
    return (i_op == DIV) || (i_op == REM);
  endfunction

  function automatic logic [RSZ-1:0] abs_val(input logic [RSZ-1:0] i_v);
    return i_v[RSZ-1] ? -i_v : i_v;
  endfunction

endpackage

// File: rtl/int_div_rem_fu_step.sv
// One radix-2 restoring step: shift {rem,quo} left, subtract the divisor when it fits.
// The comparison is made one bit wider so a remainder with its MSB set still subtracts.
module idr_step
  import int_div_rem_fu_pkg::*;
(
  input  logic [RSZ-1:0] i_rem,
  input  logic [RSZ-1:0] i_quo,
  input  logic [RSZ-1:0] i_div,
  output logic [RSZ-1:0] o_rem,
  output logic [RSZ-1:0] o_quo
);

  logic [RSZ:0]   w_shift;
  logic [RSZ-1:0] w_trial;
  logic           w_ge;

  // Trial subtraction; the low RSZ bits of the difference are exact whenever it is non-negative.
  always_comb begin
    w_shift = {i_rem, i_quo[RSZ-1]};
    w_ge    = (w_shift >= {1'b0, i_div});
    w_trial = w_shift[RSZ-1:0] - i_div;
    if (w_ge) begin
      o_rem = w_trial;
      o_quo = {i_quo[RSZ-2:0], 1'b1};
    end else begin
      o_rem = w_shift[RSZ-1:0];
      o_quo = {i_quo[RSZ-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/int_div_rem_fu.sv
// Sequential RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock.
// Optional macro IDR_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module int_div_rem_fu
  import int_div_rem_fu_pkg::*;
(
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic [RSZ-1:0] Rs1_data,
  input  logic [RSZ-1:0] Rs2_data,
  input  IDR_OP_TYPE     op,
  input  logic           start,
  input  logic           abort,
  output logic [RSZ-1:0] quotient,
  output logic [RSZ-1:0] remainder,
  output logic           done,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } IDR_STATE_TYPE;

  IDR_STATE_TYPE     r_state;
  IDR_OP_TYPE        r_op;
  logic              r_sgn_a;
  logic              r_sgn_b;
  logic [CNT_SZ-1:0] r_cnt;
  logic [RSZ-1:0]    r_rem;
  logic [RSZ-1:0]    r_quo;
  logic [RSZ-1:0]    r_div;
  logic [RSZ-1:0]    r_quotient;
  logic [RSZ-1:0]    r_remainder;
  logic              r_done;
  logic              r_busy;

  logic              w_accept;
  logic              w_signed;
  logic [RSZ-1:0]    w_abs_a;
  logic [RSZ-1:0]    w_abs_b;
  logic              w_div0;
  logic              w_ovf;
  logic              w_early;
  logic              w_neg_q;
  logic              w_neg_r;
  logic [RSZ-1:0]    w_rem_nxt;
  logic [RSZ-1:0]    w_quo_nxt;

  // Accept decode and fast-path detection on the raw operands.
  always_comb begin
    w_accept = start && !abort && (r_state != CALC);
    w_signed = is_signed_op(op);
    w_abs_a  = w_signed ? abs_val(Rs1_data) : Rs1_data;
    w_abs_b  = w_signed ? abs_val(Rs2_data) : Rs2_data;
    w_div0   = (Rs2_data == {RSZ{1'b0}});
    w_ovf    = w_signed && (Rs1_data == {1'b1, {(RSZ-1){1'b0}}})
                        && (Rs2_data == {RSZ{1'b1}});
`ifdef IDR_EARLY_OUT_EN
    w_early  = !w_div0 && (w_abs_a < w_abs_b);
`else
    w_early  = 1'b0;
`endif
    w_neg_q  = is_signed_op(r_op) && (r_sgn_a ^ r_sgn_b);
    w_neg_r  = is_signed_op(r_op) && r_sgn_a;
  end

  idr_step u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  // Control FSM and working registers; results are only written on entry to DONE.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state     <= IDLE;
      r_op        <= DIV;
      r_sgn_a     <= 1'b0;
      r_sgn_b     <= 1'b0;
      r_cnt       <= {CNT_SZ{1'b0}};
      r_rem       <= {RSZ{1'b0}};
      r_quo       <= {RSZ{1'b0}};
      r_div       <= {RSZ{1'b0}};
      r_quotient  <= {RSZ{1'b0}};
      r_remainder <= {RSZ{1'b0}};
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        CALC: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (r_cnt == {CNT_SZ{1'b0}}) begin
              r_state     <= DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_quotient  <= w_neg_q ? -w_quo_nxt : w_quo_nxt;
              r_remainder <= w_neg_r ? -w_rem_nxt : w_rem_nxt;
            end else begin
              r_cnt  <= r_cnt - CNT_ONE;
              r_done <= 1'b0;
            end
          end
        end
        IDLE, DONE: begin
          if (w_accept) begin
            r_op    <= op;
            r_sgn_a <= Rs1_data[RSZ-1];
            r_sgn_b <= Rs2_data[RSZ-1];
            if (w_div0) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_quotient  <= {RSZ{1'b1}};
              r_remainder <= Rs1_data;
            end else if (w_ovf) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_quotient  <= {1'b1, {(RSZ-1){1'b0}}};
              r_remainder <= {RSZ{1'b0}};
            end else if (w_early) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_quotient  <= {RSZ{1'b0}};
              r_remainder <= Rs1_data;
            end else begin
              r_state <= CALC;
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
              r_cnt   <= CNT_LAST;
              r_rem   <= {RSZ{1'b0}};
              r_quo   <= w_abs_a;
              r_div   <= w_abs_b;
            end
          end else begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_int_div_rem_fu.sv
// Directed self-checking bench for int_div_rem_fu: fast paths, iteration, abort, reset.
// Expected early-out latency follows IDR_EARLY_OUT_EN.
module tb_int_div_rem_fu;
  import int_div_rem_fu_pkg::*;

  logic           clk_in;
  logic           reset_in;
  logic [RSZ-1:0] Rs1_data;
  logic [RSZ-1:0] Rs2_data;
  IDR_OP_TYPE     op;
  logic           start;
  logic           abort;
  logic [RSZ-1:0] quotient;
  logic [RSZ-1:0] remainder;
  logic           done;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef IDR_EARLY_OUT_EN
  localparam int EO_CYC = 1;
`else
  localparam int EO_CYC = 33;
`endif

  int_div_rem_fu dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .Rs1_data  (Rs1_data),
    .Rs2_data  (Rs2_data),
    .op        (op),
    .start     (start),
    .abort     (abort),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic launch(input IDR_OP_TYPE i_op, input logic [31:0] a, input logic [31:0] b);
    op       = i_op;
    Rs1_data = a;
    Rs2_data = b;
    start    = 1'b1;
    @(posedge clk_in);
    #1 start = 1'b0;
  endtask

  // Returns the cycle number (1 = first cycle after accept) in which done is seen, 0 on timeout.
  task automatic wait_done(input int max_cyc, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      if (!seen) begin
        @(negedge clk_in);
        if (done) begin
          seen = 1'b1;
          cyc  = i;
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input IDR_OP_TYPE i_op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_q, input logic [31:0] exp_r);
    int cyc;
    launch(i_op, a, b);
    wait_done(40, cyc);
    check_val({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    check_val({tag, "_q"}, quotient, exp_q);
    check_val({tag, "_r"}, remainder, exp_r);
  endtask

  initial begin
    int n_done;
    int first;

    reset_in = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    op       = DIVU;
    Rs1_data = 32'h0;
    Rs2_data = 32'h0;
    repeat (2) @(negedge clk_in);
    check_val("rst_q", quotient, 32'h0);
    check_val("rst_r", remainder, 32'h0);
    check_val("rst_done", {31'h0, done}, 32'h0);
    check_val("rst_busy", {31'h0, busy}, 32'h0);
    reset_in = 1'b0;
    @(negedge clk_in);

    launch(DIV, 32'd7, 32'hFFFF_FFFE);
    @(negedge clk_in);
    check_val("div_busy", {31'h0, busy}, 32'h1);
    begin
      int cyc;
      wait_done(40, cyc);
      check_val("div_cyc", 32'(cyc + 1), 32'd33);
    end
    check_val("div_q", quotient, 32'hFFFF_FFFD);
    check_val("div_r", remainder, 32'h0000_0001);
    @(negedge clk_in);
    check_val("div_pulse", {31'h0, done}, 32'h0);

    run_op("divu0", DIVU, 32'd5, 32'h0, 1, 32'hFFFF_FFFF, 32'd5);
    run_op("rem0", REM, 32'hFFFF_FFF9, 32'h0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

    run_op("ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'h0);
    run_op("b2b", REMU, 32'hFFFF_FFFF, 32'h10, 33, 32'h0FFF_FFFF, 32'hF);

    @(negedge clk_in);
    launch(REM, 32'hFFFF_FFF9, 32'd2);
    n_done = 0;
    first  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_in);
      if (done) begin
        n_done++;
        if (first == 0) first = i;
      end
      if (i == 5) begin
        check_val("busy_c5", {31'h0, busy}, 32'h1);
        op       = DIVU;
        Rs1_data = 32'd9;
        Rs2_data = 32'd3;
        start    = 1'b1;
      end
      if (i == 6) start = 1'b0;
    end
    check_val("ign_ndone", 32'(n_done), 32'd1);
    check_val("ign_cyc", 32'(first), 32'd33);
    check_val("rem_q", quotient, 32'hFFFF_FFFD);
    check_val("rem_r", remainder, 32'hFFFF_FFFF);

    launch(DIVU, 32'd100, 32'd3);
    for (int i = 1; i <= 10; i++) @(negedge clk_in);
    check_val("abt_busy10", {31'h0, busy}, 32'h1);
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
    check_val("abt_busy11", {31'h0, busy}, 32'h0);
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (done) n_done++;
    end
    check_val("abt_nodone", 32'(n_done), 32'd0);
    check_val("abt_q_hold", quotient, 32'hFFFF_FFFD);
    check_val("abt_r_hold", remainder, 32'hFFFF_FFFF);

    op       = DIVU;
    Rs1_data = 32'd8;
    Rs2_data = 32'd2;
    start    = 1'b1;
    abort    = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    abort = 1'b0;
    check_val("abtst_busy", {31'h0, busy}, 32'h0);
    check_val("abtst_done", {31'h0, done}, 32'h0);

    run_op("divu", DIVU, 32'd100, 32'd3, 33, 32'd33, 32'd1);

    @(negedge clk_in);
    launch(DIVU, 32'd1000, 32'd7);
    for (int i = 1; i <= 12; i++) @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
    check_val("mrst_busy", {31'h0, busy}, 32'h0);
    check_val("mrst_done", {31'h0, done}, 32'h0);
    check_val("mrst_q", quotient, 32'h0);
    check_val("mrst_r", remainder, 32'h0);

    run_op("eo_divu", DIVU, 32'd3, 32'd10, EO_CYC, 32'h0, 32'd3);
    run_op("eo_rem", REM, 32'hFFFF_FFFD, 32'd10, EO_CYC, 32'h0, 32'hFFFF_FFFD);
    run_op("big", DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 33, 32'd1, 32'h7FFF_FFFE);
    run_op("neg", DIV, 32'hFFFF_FFF8, 32'd3, 33, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
    run_op("div1", DIVU, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
